cpu_clock_ctrl: RTL and testbench

//   Consumes the divided clock from the clock divider as a data signal and

---
 rtl/cpu_clock_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Turns rising edges of the divided clock (sampled as data in the clk_in
//   domain) into single-cycle clock enables for the rv32 core. It also adds
//   run/halt/single-step control, a debounced step button, a retired-cycle
//   counter and a cycle-count breakpoint.
//
// Ports
//   clk_in          in   fast system clock, the only clock
//   rst_n           in   asynchronous reset, active low
//   div_clk_i       in   divided clock, sampled as data
//   run_req_i       in   1-cycle pulse: start free running
//   halt_req_i      in   1-cycle pulse: stop (wins over everything)
//   step_btn_i      in   raw asynchronous push button, active high
//   bp_en_i         in   breakpoint enable
//   bp_count_i      in   halt when cycle_count_o reaches this value
//   cpu_ce_o        out  1-cycle clock enable to the core
//   running_o       out  1 while in RUN
//   cycle_count_o   out  number of cpu_ce_o pulses issued (wraps)
//   bp_hit_o        out  sticky: last halt came from the breakpoint
//
// state      | meaning
// -----------+------------------------------------------------------
// HALT       | core stopped; waits for run_req or a debounced step
// RUN        | one cpu_ce per div_clk rising edge; breakpoint checked
// STEP_WAIT  | waiting for the next tick to issue exactly one cpu_ce
module cpu_clock_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_WIDTH       = 32,
   parameter bit          RESET_RUN       = 1'b0
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 div_clk_i,
   input  logic                 run_req_i,
   input  logic                 halt_req_i,
   input  logic                 step_btn_i,
   input  logic                 bp_en_i,
   input  logic [CNT_WIDTH-1:0] bp_count_i,
   output logic                 cpu_ce_o,
   output logic                 running_o,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic                 bp_hit_o
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_HALT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STEP_WAIT = 2'd2
   } state_t;

   localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

   logic                 div_s0_q, div_s1_q, div_s2_q;
   logic                 btn_s0_q, btn_s1_q, btn_s2_q;
   logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
   logic                 btn_db_q, btn_db_d;
   logic                 pending_q, pending_d;
   state_t               state_q, state_d;
   logic                 ce_q, ce_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 bp_hit_q, bp_hit_d;

   logic                 tick;
   logic                 db_stable;
   logic                 db_rise;
   logic                 pending_clr;
   logic [CNT_WIDTH-1:0] count_inc;

   assign tick      = div_s1_q & ~div_s2_q;
   assign count_inc = count_q + CNT_WIDTH'(1);

   // db_cnt_q saturates once the synchronised level has been stable long
   // enough; btn_s2_q is the level that has been stable over that window.
   assign db_stable = (db_cnt_q == DB_W'(DEBOUNCE_CYCLES));
   assign db_rise   = db_stable & btn_s2_q & ~btn_db_q;

   always_comb begin
      db_cnt_d = db_cnt_q;
      if (btn_s1_q != btn_s2_q) begin
         db_cnt_d = '0;
      end else if (!db_stable) begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
      btn_db_d = db_stable ? btn_s2_q : btn_db_q;
   end

   always_comb begin
      state_d     = state_q;
      ce_d        = 1'b0;
      count_d     = count_q;
      bp_hit_d    = bp_hit_q;
      pending_clr = 1'b0;
      case (state_q)
         ST_HALT: begin
            if (halt_req_i) begin
               state_d = ST_HALT;
            end else if (run_req_i) begin
               state_d  = ST_RUN;
               bp_hit_d = 1'b0;
            end else if (pending_q) begin
               state_d  = ST_STEP_WAIT;
               bp_hit_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (halt_req_i) begin
               state_d = ST_HALT;
            end else if (tick) begin
               ce_d    = 1'b1;
               count_d = count_inc;
               if (bp_en_i && (count_inc == bp_count_i)) begin
                  state_d  = ST_HALT;
                  bp_hit_d = 1'b1;
               end
            end
         end
         ST_STEP_WAIT: begin
            if (halt_req_i) begin
               state_d     = ST_HALT;
               pending_clr = 1'b1;
            end else if (tick) begin
               ce_d        = 1'b1;
               count_d     = count_inc;
               state_d     = ST_HALT;
               pending_clr = 1'b1;
            end
         end
         default: state_d = ST_HALT;
      endcase
      // A step request that shows up while free running is thrown away.
      pending_d = (state_q == ST_RUN) ? 1'b0 : (db_rise | (pending_q & ~pending_clr));
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_s0_q  <= 1'b0;
         div_s1_q  <= 1'b0;
         div_s2_q  <= 1'b0;
         btn_s0_q  <= 1'b0;
         btn_s1_q  <= 1'b0;
         btn_s2_q  <= 1'b0;
         db_cnt_q  <= '0;
         btn_db_q  <= 1'b0;
         pending_q <= 1'b0;
         state_q   <= RESET_STATE;
         ce_q      <= 1'b0;
         count_q   <= '0;
         bp_hit_q  <= 1'b0;
      end else begin
         div_s0_q  <= div_clk_i;
         div_s1_q  <= div_s0_q;
         div_s2_q  <= div_s1_q;
         btn_s0_q  <= step_btn_i;
         btn_s1_q  <= btn_s0_q;
         btn_s2_q  <= btn_s1_q;
         db_cnt_q  <= db_cnt_d;
         btn_db_q  <= btn_db_d;
         pending_q <= pending_d;
         state_q   <= state_d;
         ce_q      <= ce_d;
         count_q   <= count_d;
         bp_hit_q  <= bp_hit_d;
      end
   end

   assign cpu_ce_o      = ce_q;
   assign running_o     = (state_q == ST_RUN);
   assign cycle_count_o = count_q;
   assign bp_hit_o      = bp_hit_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl
//   Directed scenarios followed by a randomized phase, all checked cycle by
//   cycle against a behavioural model that works from input histories.
module tb_cpu_clock_ctrl;

   localparam int CW  = 4;
   localparam int DB  = 16;
   localparam int HL  = DB + 4;          // history depth kept by the model
   localparam int M_HALT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_STEPW = 2;

   logic          clk_in   = 1'b0;
   logic          rst_n    = 1'b0;
   logic          div_clk  = 1'b0;
   logic          run_req  = 1'b0;
   logic          halt_req = 1'b0;
   logic          step_btn = 1'b0;
   logic          bp_en    = 1'b0;
   logic [CW-1:0] bp_count = '0;
   logic          cpu_ce, running, bp_hit;
   logic [CW-1:0] cycle_count;
   logic          r_ce, r_running, r_bp_hit;
   logic [CW-1:0] r_count;

   cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW), .RESET_RUN(1'b0)) u_dut (
      .clk_in(clk_in), .rst_n(rst_n), .div_clk_i(div_clk), .run_req_i(run_req),
      .halt_req_i(halt_req), .step_btn_i(step_btn), .bp_en_i(bp_en),
      .bp_count_i(bp_count), .cpu_ce_o(cpu_ce), .running_o(running),
      .cycle_count_o(cycle_count), .bp_hit_o(bp_hit));

   cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW), .RESET_RUN(1'b1)) u_run (
      .clk_in(clk_in), .rst_n(rst_n), .div_clk_i(div_clk), .run_req_i(run_req),
      .halt_req_i(halt_req), .step_btn_i(step_btn), .bp_en_i(bp_en),
      .bp_count_i(bp_count), .cpu_ce_o(r_ce), .running_o(r_running),
      .cycle_count_o(r_count), .bp_hit_o(r_bp_hit));

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;
   int ce_seen  = 0;
   int div_mode = 2;                     // 0: period 8, 1: random, 2: held low
   int div_phase = 0;

   // model state
   int m_mode;
   int m_count;
   bit m_ce, m_bphit, m_pending, m_db;
   bit dh[$];                            // dh[m] = div_clk sampled m edges ago
   bit bh[$];                            // bh[m] = step_btn sampled m edges ago

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_HALT; m_count = 0;
      m_ce = 0; m_bphit = 0; m_pending = 0; m_db = 0;
      dh.delete(); bh.delete();
      repeat (HL) begin dh.push_back(1'b0); bh.push_back(1'b0); end
   endtask

   // One clk_in edge of the specified behaviour, using the inputs as driven now.
   task automatic model_step();
      bit tick, stable, rise, new_pend;
      dh.push_front(div_clk);  void'(dh.pop_back());
      bh.push_front(step_btn); void'(bh.pop_back());
      // div_clk first seen high two edges ago, low the edge before that
      tick = dh[2] && !dh[3];
      // synchronised button level (3 edges old) unchanged over DB cycles
      stable = 1;
      for (int i = 4; i <= DB + 3; i++) if (bh[i] != bh[3]) stable = 0;
      rise = 0;
      if (stable) begin
         rise = bh[3] && !m_db;
         m_db = bh[3];
      end
      m_ce = 0;
      new_pend = m_pending | rise;
      case (m_mode)
         M_HALT: begin
            if (halt_req) ;
            else if (run_req)   begin m_mode = M_RUN;   m_bphit = 0; end
            else if (m_pending) begin m_mode = M_STEPW; m_bphit = 0; end
         end
         M_RUN: begin
            new_pend = 0;
            if (halt_req) m_mode = M_HALT;
            else if (tick) begin
               m_ce = 1;
               m_count = (m_count + 1) % (1 << CW);
               if (bp_en && m_count == int'(bp_count)) begin
                  m_mode = M_HALT; m_bphit = 1;
               end
            end
         end
         default: begin
            if (halt_req) begin m_mode = M_HALT; new_pend = rise; end
            else if (tick) begin
               m_ce = 1;
               m_count = (m_count + 1) % (1 << CW);
               m_mode = M_HALT; new_pend = rise;
            end
         end
      endcase
      m_pending = new_pend;
   endtask

   task automatic cyc();
      case (div_mode)
         0: begin div_clk = (div_phase % 8) < 4; div_phase++; end
         1: if ($urandom_range(0, 2) == 0) div_clk = ~div_clk;
         default: div_clk = 1'b0;
      endcase
      model_step();
      @(posedge clk_in); #1;
      if (cpu_ce) ce_seen++;
      chk("cpu_ce", cpu_ce, m_ce);
      chk("running", running, m_mode == M_RUN);
      chk("cycle_count", cycle_count, m_count);
      chk("bp_hit", bp_hit, m_bphit);
   endtask

   task automatic pulse_run();  run_req = 1;  cyc(); run_req = 0;  endtask
   task automatic pulse_halt(); halt_req = 1; cyc(); halt_req = 0; endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_cpu_ce", cpu_ce, 0);
      chk("rst_running", running, 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_bp_hit", bp_hit, 0);
      model_reset();
      repeat (2) @(posedge clk_in);
      #1 rst_n = 1'b1;
      chk("rst_run_instance_running", r_running, 1);
   endtask

   task automatic press_step(input int hold);
      step_btn = 1; repeat (hold) cyc();
      step_btn = 0; repeat (DB + 9) cyc();
   endtask

   initial begin
      int c0, btn_left;
      bit found;

      // 1: halted after reset, div_clk toggling
      do_reset();
      div_mode = 0; div_phase = 0;
      repeat (24) cyc();
      div_mode = 2; repeat (4) cyc();
      chk("t1_running", running, 0);
      chk("t1_count", cycle_count, 0);

      // 2: five div_clk rising edges while running
      pulse_run();
      ce_seen = 0; div_mode = 0; div_phase = 0;
      repeat (40) cyc();
      div_mode = 2; repeat (4) cyc();
      chk("t2_pulses", ce_seen, 5);
      chk("t2_count", cycle_count, 5);

      // 3: breakpoint at 3
      do_reset();
      bp_en = 1; bp_count = 3;
      pulse_run();
      ce_seen = 0; div_mode = 0; div_phase = 0;
      repeat (64) cyc();
      chk("t3_pulses", ce_seen, 3);
      chk("t3_running", running, 0);
      chk("t3_bp_hit", bp_hit, 1);
      chk("t3_count", cycle_count, 3);
      pulse_run();
      chk("t3_bp_clear", bp_hit, 0);
      pulse_halt();
      bp_en = 0;

      // 4: bounced button then a long press gives exactly one step
      c0 = m_count; ce_seen = 0;
      repeat (5) begin
         step_btn = 1; repeat (3) cyc();
         step_btn = 0; repeat (3) cyc();
      end
      press_step(40);
      chk("t4_pulses", ce_seen, 1);
      chk("t4_count", cycle_count, (c0 + 1) % 16);
      chk("t4_running", running, 0);

      // 5: halt on a tick cycle suppresses it; run+halt together stays halted
      pulse_run();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dh[1] && !dh[2]) found = 1;
         else cyc();
      end
      chk("t5_tick_found", found, 1);
      pulse_halt();
      chk("t5_no_ce", cpu_ce, 0);
      chk("t5_running", running, 0);
      run_req = 1; halt_req = 1; cyc(); run_req = 0; halt_req = 0;
      repeat (3) cyc();
      chk("t5_both_running", running, 0);

      // 6: count wrap via a step, then reset during STEP_WAIT
      do_reset();
      bp_en = 1; bp_count = 15;
      pulse_run();
      div_mode = 0; div_phase = 0;
      repeat (140) cyc();
      chk("t6_bp_count", cycle_count, 15);
      chk("t6_bp_hit", bp_hit, 1);
      press_step(40);
      chk("t6_wrap", cycle_count, 0);
      div_mode = 2; step_btn = 1;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         cyc();
         if (m_mode == M_STEPW) found = 1;
      end
      chk("t6_step_wait", found, 1);
      repeat (2) cyc();
      step_btn = 0;
      do_reset();

      // randomized phase
      bp_en = 0; btn_left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin div_mode = (n / 200) % 2; div_phase = $urandom_range(0, 7); end
         run_req  = ($urandom_range(0, 39) == 0);
         halt_req = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 99) == 0) bp_en = $urandom_range(0, 1);
         if ($urandom_range(0, 49) == 0) bp_count = CW'($urandom_range(0, 15));
         if (btn_left == 0) begin
            step_btn = $urandom_range(0, 1);
            btn_left = $urandom_range(1, 40);
         end
         btn_left--;
         cyc();
         if ($urandom_range(0, 999) == 0) begin
            run_req = 0; halt_req = 0;
            do_reset();
         end
      end
      run_req = 0; halt_req = 0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
